// File: rtl/ace_aw_snoop_dispatcher.sv
// rtl/ace_aw_snoop_dispatcher.sv - ACE write snoop dispatcher between the AW decoder and the memory-side AW
module ace_aw_snoop_dispatcher #(
    parameter int NoMstPorts = 4,
    parameter int AddrWidth  = 64,
    parameter int IdxWidth   = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [AddrWidth-1:0]    aw_addr_i,
    input  logic [IdxWidth-1:0]     aw_src_i,
    input  logic                    snooping_i,
    input  logic [3:0]              acsnoop_i,
    input  logic                    illegal_trs_i,
    output logic [NoMstPorts-1:0]   ac_valid_o,
    input  logic [NoMstPorts-1:0]   ac_ready_i,
    output logic [AddrWidth-1:0]    ac_addr_o,
    output logic [3:0]              ac_snoop_o,
    input  logic [NoMstPorts-1:0]   cr_valid_i,
    output logic [NoMstPorts-1:0]   cr_ready_o,
    input  logic [5*NoMstPorts-1:0] cr_resp_i,
    output logic                    mem_aw_valid_o,
    input  logic                    mem_aw_ready_i,
    output logic [AddrWidth-1:0]    mem_aw_addr_o,
    output logic [NoMstPorts-1:0]   cd_mask_o,
    output logic                    pass_dirty_o,
    output logic                    snoop_err_o,
    output logic                    illegal_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        FWD   = 2'd2
    } state_e;

    state_e                state, state_next;
    logic [AddrWidth-1:0]  addr_q;
    logic [3:0]            acsnoop_q;
    logic [NoMstPorts-1:0] target_q, sent_q, resp_q, cd_mask_q;
    logic                  pass_dirty_q, snoop_err_q, illegal_q;

    logic                  accept;
    logic [NoMstPorts-1:0] new_target, ac_hs, cr_hs, cr_dt;
    logic                  cr_err, cr_pd;

    // WasUnique and IsShared do not influence the memory-side write.
    logic                  unused_cr_bits;
    assign unused_cr_bits = ^cr_resp_i;

    assign accept = aw_valid_i & aw_ready_o;
    assign ac_hs  = ac_valid_o & ac_ready_i;
    assign cr_hs  = cr_valid_i & cr_ready_o;

    always_comb begin
        new_target = '0;
        cr_dt      = '0;
        cr_err     = 1'b0;
        cr_pd      = 1'b0;
        for (int i = 0; i < NoMstPorts; i++) begin
            new_target[i] = (int'(aw_src_i) != i);
            cr_dt[i]      = cr_hs[i] & cr_resp_i[5*i];
            cr_err        = cr_err | (cr_hs[i] & cr_resp_i[5*i+1]);
            cr_pd         = cr_pd  | (cr_hs[i] & cr_resp_i[5*i+2]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        aw_ready_o     = 1'b0;
        ac_valid_o     = '0;
        ac_addr_o      = '0;
        ac_snoop_o     = '0;
        cr_ready_o     = '0;
        mem_aw_valid_o = 1'b0;
        mem_aw_addr_o  = '0;
        cd_mask_o      = '0;
        pass_dirty_o   = 1'b0;
        snoop_err_o    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so every output reads 0 while reset is held.
                aw_ready_o = rst_ni;
                if (aw_valid_i && rst_ni && !illegal_trs_i) begin
                    if (snooping_i && (|new_target)) begin
                        state_next = SNOOP;
                    end else begin
                        state_next = FWD;
                    end
                end
            end
            SNOOP: begin
                ac_valid_o = target_q & ~sent_q;
                ac_addr_o  = addr_q;
                ac_snoop_o = acsnoop_q;
                // A port whose AC is handshaking this cycle is not yet in sent_q,
                // so its CR can only be taken from the following cycle on.
                cr_ready_o = sent_q & ~resp_q;
                if ((resp_q | (cr_valid_i & sent_q & ~resp_q)) == target_q) begin
                    state_next = FWD;
                end
            end
            FWD: begin
                mem_aw_valid_o = 1'b1;
                mem_aw_addr_o  = addr_q;
                cd_mask_o      = cd_mask_q;
                pass_dirty_o   = pass_dirty_q;
                snoop_err_o    = snoop_err_q;
                if (mem_aw_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q       <= '0;
            acsnoop_q    <= '0;
            target_q     <= '0;
            sent_q       <= '0;
            resp_q       <= '0;
            cd_mask_q    <= '0;
            pass_dirty_q <= 1'b0;
            snoop_err_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            illegal_q <= accept & illegal_trs_i;
            if (accept) begin
                addr_q    <= aw_addr_i;
                acsnoop_q <= acsnoop_i;
                target_q  <= (snooping_i && !illegal_trs_i) ? new_target : '0;
            end
            sent_q       <= sent_q | ac_hs;
            resp_q       <= resp_q | cr_hs;
            cd_mask_q    <= cd_mask_q | cr_dt;
            pass_dirty_q <= pass_dirty_q | cr_pd;
            snoop_err_q  <= snoop_err_q | cr_err;
            if ((state == FWD) && mem_aw_ready_i) begin
                target_q     <= '0;
                sent_q       <= '0;
                resp_q       <= '0;
                cd_mask_q    <= '0;
                pass_dirty_q <= 1'b0;
                snoop_err_q  <= 1'b0;
            end
        end
    end

    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_ace_aw_snoop_dispatcher.sv
// tb/tb_ace_aw_snoop_dispatcher.sv - self-checking bench for ace_aw_snoop_dispatcher
module tb_ace_aw_snoop_dispatcher;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int IW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          aw_valid_i;
    logic          aw_ready_o;
    logic [AW-1:0] aw_addr_i;
    logic [IW-1:0] aw_src_i;
    logic          snooping_i;
    logic [3:0]    acsnoop_i;
    logic          illegal_trs_i;
    logic [N-1:0]  ac_valid_o;
    logic [N-1:0]  ac_ready_i;
    logic [AW-1:0] ac_addr_o;
    logic [3:0]    ac_snoop_o;
    logic [N-1:0]  cr_valid_i;
    logic [N-1:0]  cr_ready_o;
    logic [5*N-1:0] cr_resp_i;
    logic          mem_aw_valid_o;
    logic          mem_aw_ready_i;
    logic [AW-1:0] mem_aw_addr_o;
    logic [N-1:0]  cd_mask_o;
    logic          pass_dirty_o;
    logic          snoop_err_o;
    logic          illegal_o;

    always #5 clk_i = ~clk_i;

    ace_aw_snoop_dispatcher #(.NoMstPorts(N), .AddrWidth(AW), .IdxWidth(IW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_src_i(aw_src_i), .snooping_i(snooping_i), .acsnoop_i(acsnoop_i),
        .illegal_trs_i(illegal_trs_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
        .ac_snoop_o(ac_snoop_o),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .mem_aw_valid_o(mem_aw_valid_o), .mem_aw_ready_i(mem_aw_ready_i),
        .mem_aw_addr_o(mem_aw_addr_o), .cd_mask_o(cd_mask_o),
        .pass_dirty_o(pass_dirty_o), .snoop_err_o(snoop_err_o), .illegal_o(illegal_o)
    );

    int errors = 0;
    int checks = 0;

    // Per-write responder knobs, set before each run_write call.
    int         ac_dly [N];
    int         cr_dly [N];
    logic [4:0] rsp    [N];
    int         mem_dly;

    // Observations from the most recent write, for directed latency/status checks.
    int         mem_first;
    logic [N-1:0] obs_cd;
    logic       obs_pd;
    logic       obs_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        aw_valid_i     = 1'b0;
        aw_addr_i      = '0;
        aw_src_i       = '0;
        snooping_i     = 1'b0;
        acsnoop_i      = '0;
        illegal_trs_i  = 1'b0;
        ac_ready_i     = '0;
        cr_valid_i     = '0;
        cr_resp_i      = '0;
        mem_aw_ready_i = 1'b0;
    endtask

    task automatic run_write(input logic [63:0] addr, input int src, input bit snp,
                             input logic [3:0] acs, input bit ill);
        logic [N-1:0] tgt, acseen, crdone, exp_acv, exp_crr, exp_cd;
        bit           exp_memv, exp_pd, exp_err, done;
        int           hs_cyc [N];
        int           memwait;
        tgt = '0; exp_cd = '0; exp_pd = 0; exp_err = 0;
        acseen = '0; crdone = '0; done = 0; memwait = 0; mem_first = -1;
        for (int p = 0; p < N; p++) begin
            hs_cyc[p] = 0;
            tgt[p] = snp && !ill && (p != src);
            if (tgt[p]) begin
                exp_cd[p] = rsp[p][0];
                exp_err   = exp_err | rsp[p][1];
                exp_pd    = exp_pd  | rsp[p][2];
            end
        end
        @(negedge clk_i);
        aw_valid_i = 1'b1; aw_addr_i = addr; aw_src_i = IW'(src);
        snooping_i = snp; acsnoop_i = acs; illegal_trs_i = ill;
        #1 chk("aw_ready_idle", 64'(aw_ready_o), 64'(1));
        @(posedge clk_i);
        @(negedge clk_i);
        aw_valid_i = 1'b0; aw_addr_i = {$urandom, $urandom};
        snooping_i = 1'($urandom); illegal_trs_i = 1'($urandom);
        if (ill) begin
            #1;
            chk("illegal_pulse", 64'(illegal_o), 64'(1));
            chk("illegal_no_ac", 64'(ac_valid_o), 64'(0));
            chk("illegal_no_mem", 64'(mem_aw_valid_o), 64'(0));
            chk("illegal_idle", 64'(aw_ready_o), 64'(1));
            @(negedge clk_i);
            #1 chk("illegal_one_cycle", 64'(illegal_o), 64'(0));
            chk("illegal_no_mem2", 64'(mem_aw_valid_o), 64'(0));
            return;
        end
        for (int n = 1; n <= 80 && !done; n++) begin
            if (n > 1) @(negedge clk_i);
            exp_acv  = tgt & ~acseen;
            exp_crr  = acseen & ~crdone;
            exp_memv = ((crdone & tgt) == tgt);
            for (int p = 0; p < N; p++) begin
                ac_ready_i[p] = (n >= 1 + ac_dly[p]);
                if (acseen[p] && !crdone[p]) begin
                    cr_valid_i[p]       = (n >= hs_cyc[p] + 1 + cr_dly[p]);
                    cr_resp_i[5*p +: 5] = rsp[p];
                end else begin
                    // Responses on ports not awaiting a CR must be ignored.
                    cr_valid_i[p]       = 1'($urandom);
                    cr_resp_i[5*p +: 5] = 5'($urandom);
                end
            end
            mem_aw_ready_i = exp_memv ? (memwait >= mem_dly) : 1'($urandom);
            #1;
            chk("ac_valid", 64'(ac_valid_o), 64'(exp_acv));
            chk("cr_ready", 64'(cr_ready_o), 64'(exp_crr));
            chk("mem_valid", 64'(mem_aw_valid_o), 64'(exp_memv));
            chk("aw_ready_busy", 64'(aw_ready_o), 64'(0));
            chk("illegal_quiet", 64'(illegal_o), 64'(0));
            if (|exp_acv) begin
                chk("ac_addr", ac_addr_o, addr);
                chk("ac_snoop", 64'(ac_snoop_o), 64'(acs));
            end
            if (exp_memv) begin
                chk("mem_addr", mem_aw_addr_o, addr);
                chk("cd_mask", 64'(cd_mask_o), 64'(exp_cd));
                chk("pass_dirty", 64'(pass_dirty_o), 64'(exp_pd));
                chk("snoop_err", 64'(snoop_err_o), 64'(exp_err));
                if (mem_first < 0) begin
                    mem_first = n; obs_cd = cd_mask_o; obs_pd = pass_dirty_o; obs_err = snoop_err_o;
                end
                if (mem_aw_ready_i) done = 1;
                else memwait++;
            end else begin
                chk("cd_mask_idle", 64'(cd_mask_o), 64'(0));
                chk("pd_idle", 64'(pass_dirty_o), 64'(0));
                chk("err_idle", 64'(snoop_err_o), 64'(0));
            end
            for (int p = 0; p < N; p++) begin
                if (exp_acv[p] && ac_ready_i[p]) begin
                    acseen[p] = 1'b1; hs_cyc[p] = n;
                end
                if (exp_crr[p] && cr_valid_i[p]) crdone[p] = 1'b1;
            end
        end
        chk("write_done", 64'(done), 64'(1));
        @(negedge clk_i);
        ac_ready_i = '0; cr_valid_i = '0; mem_aw_ready_i = 1'b0;
        #1;
        chk("back_idle", 64'(aw_ready_o), 64'(1));
        chk("mem_dropped", 64'(mem_aw_valid_o), 64'(0));
    endtask

    task automatic set_knobs(input int acd, input int crd, input logic [4:0] r, input int md);
        for (int p = 0; p < N; p++) begin
            ac_dly[p] = acd; cr_dly[p] = crd; rsp[p] = r;
        end
        mem_dly = md;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        set_knobs(0, 0, 5'b0, 0);
        mem_first = -1;
        obs_cd = '0; obs_pd = 1'b0; obs_err = 1'b0;

        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_aw_ready", 64'(aw_ready_o), 64'(0));
        chk("rst_ac_valid", 64'(ac_valid_o), 64'(0));
        chk("rst_cr_ready", 64'(cr_ready_o), 64'(0));
        chk("rst_mem_valid", 64'(mem_aw_valid_o), 64'(0));
        chk("rst_illegal", 64'(illegal_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Snoop from port 1, CleanInvalid, everyone ready.
        set_knobs(0, 0, 5'b0, 0);
        run_write(64'h0000_0000_dead_0040, 1, 1'b1, 4'h9, 1'b0);
        chk("lat_snoop", 64'(mem_first), 64'(3));

        // Non-snooping write.
        set_knobs(0, 0, 5'b11111, 0);
        run_write(64'h1000, 2, 1'b0, 4'h0, 1'b0);
        chk("lat_nosnoop", 64'(mem_first), 64'(1));
        chk("nosnoop_status", 64'({obs_cd, obs_pd, obs_err}), 64'(0));

        // Illegal has priority over snooping.
        run_write(64'h2000, 0, 1'b1, 4'h9, 1'b1);

        // Port 3 AC delayed 5 cycles, CRs in order 2,0,3 with mixed responses.
        set_knobs(0, 0, 5'b0, 0);
        ac_dly[3] = 5;
        cr_dly[0] = 1;
        rsp[0] = 5'b00101; rsp[1] = 5'b11111; rsp[2] = 5'b00010; rsp[3] = 5'b00000;
        run_write(64'h3000, 1, 1'b1, 4'h9, 1'b0);
        chk("lat_delayed", 64'(mem_first), 64'(8));
        chk("dir_cd_mask", 64'(obs_cd), 64'(4'b0001));
        chk("dir_pass_dirty", 64'(obs_pd), 64'(1));
        chk("dir_snoop_err", 64'(obs_err), 64'(1));

        // Memory side stalls for 4 cycles.
        set_knobs(0, 1, 5'b00001, 4);
        run_write(64'h4000, 3, 1'b1, 4'h7, 1'b0);

        // Randomized writes against the model.
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < N; p++) begin
                ac_dly[p] = $urandom_range(0, 3);
                cr_dly[p] = $urandom_range(0, 3);
                rsp[p]    = 5'($urandom);
            end
            mem_dly = $urandom_range(0, 3);
            run_write({$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom),
                      4'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) @(negedge clk_i);
        end

        // Reset in the middle of SNOOP abandons the transaction.
        @(negedge clk_i);
        aw_valid_i = 1'b1; aw_addr_i = 64'h5000; aw_src_i = 2'd0;
        snooping_i = 1'b1; acsnoop_i = 4'h9; illegal_trs_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        aw_valid_i = 1'b0; ac_ready_i = 4'b0010;
        #1 chk("mid_ac_first", 64'(ac_valid_o), 64'(4'b1110));
        @(negedge clk_i);
        #1 chk("mid_ac_held", 64'(ac_valid_o), 64'(4'b1100));
        chk("mid_cr_ready", 64'(cr_ready_o), 64'(4'b0010));
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_ac", 64'(ac_valid_o), 64'(0));
        chk("mid_rst_cr", 64'(cr_ready_o), 64'(0));
        chk("mid_rst_aw_ready", 64'(aw_ready_o), 64'(0));
        chk("mid_rst_mem", 64'(mem_aw_valid_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1; ac_ready_i = 4'hF; cr_valid_i = 4'hF; mem_aw_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            chk("post_rst_ac", 64'(ac_valid_o), 64'(0));
            chk("post_rst_mem", 64'(mem_aw_valid_o), 64'(0));
            chk("post_rst_idle", 64'(aw_ready_o), 64'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
